// File: rtl/crc_three_pkg.sv
// Shared constants, deserializer state type and the 3-bit CRC function
// for the serial CRC receive checker.
package crc_three_pkg;

  localparam int DATA_W = 3;
  localparam int CRC_W  = 4;
  localparam int CW_W   = 7;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } deser_state_e;

  function automatic logic [CRC_W-1:0] crc_three_calc(
    input logic [DATA_W-1:0] data
  );
    return {data[2] ^ data[1],
            data[1] ^ data[0],
            data[2] ^ data[1] ^ data[0],
            data[2] ^ data[0]};
  endfunction

endpackage

// File: rtl/crc_three_rx_if.sv
// Serial-in / result-out bundle of the CRC receive checker.
// slave is the checker side, master the link/consumer side.
interface crc_three_rx_if
  import crc_three_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) ();

  logic                 i_bit_valid;
  logic                 i_bit;
  logic                 i_sof;
  logic                 i_ready;
  logic                 o_valid;
  logic [DATA_W-1:0]    o_data;
  logic [CRC_W-1:0]     o_syndrome;
  logic                 o_crc_ok;
  logic                 o_frame_err;
  logic                 o_overrun;
  logic [ERR_CNT_W-1:0] o_err_cnt;

  modport slave (
    input  i_bit_valid, i_bit, i_sof, i_ready,
    output o_valid, o_data, o_syndrome, o_crc_ok,
    output o_frame_err, o_overrun, o_err_cnt
  );

  modport master (
    output i_bit_valid, i_bit, i_sof, i_ready,
    input  o_valid, o_data, o_syndrome, o_crc_ok,
    input  o_frame_err, o_overrun, o_err_cnt
  );

endinterface

// File: rtl/crc_three_deser.sv
// Bit counter, shift register and SOF/abort FSM. o_cw/o_done are
// combinational so the result can be captured on the bit-6 edge.
module crc_three_deser
  import crc_three_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_bit_valid,
  input  logic            i_bit,
  input  logic            i_sof,
  output logic [CW_W-1:0] o_cw,
  output logic            o_done,
  output logic            o_frame_err
);

  deser_state_e    state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [CW_W-1:0] sh_q, sh_d;
  logic            ferr_q, ferr_d;
  logic            sof_hit, bit_hit;
  logic [2:0]      idx, pos;

  assign sof_hit = i_bit_valid && i_sof;
  assign bit_hit = i_bit_valid && !i_sof
                && (state_q == ST_SHIFT);
  assign idx = sof_hit ? 3'd0 : cnt_q;
  assign pos = MSB_FIRST ? (3'(CW_W - 1) - idx) : idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ferr_d  = 1'b0;
    o_done  = 1'b0;
    unique case (1'b1)
      sof_hit: begin
        ferr_d    = (state_q == ST_SHIFT);
        sh_d      = '0;
        sh_d[pos] = i_bit;
        cnt_d     = 3'd1;
        state_d   = ST_SHIFT;
      end
      bit_hit: begin
        sh_d[pos] = i_bit;
        if (cnt_q == 3'(CW_W - 1)) begin
          o_done  = 1'b1;
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_cw        = sh_d;
  assign o_frame_err = ferr_q;

endmodule

// File: rtl/crc_three_rx.sv
// Serial CRC receive checker: CRC compare, 1-entry result buffer,
// overrun detection and saturating error counter.
module crc_three_rx
  import crc_three_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int ERR_CNT_W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  crc_three_rx_if.slave  bus
);

  logic [CW_W-1:0]      cw;
  logic                 done;
  logic                 frame_err;
  logic [CRC_W-1:0]     syn;
  logic                 accept;

  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [CRC_W-1:0]     syn_q, syn_d;
  logic                 ok_q, ok_d;
  logic                 ovr_q, ovr_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  crc_three_deser #(
    .MSB_FIRST (MSB_FIRST)
  ) u_deser (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_bit_valid (bus.i_bit_valid),
    .i_bit       (bus.i_bit),
    .i_sof       (bus.i_sof),
    .o_cw        (cw),
    .o_done      (done),
    .o_frame_err (frame_err)
  );

  assign syn = cw[CRC_W-1:0]
             ^ crc_three_calc(cw[CW_W-1:CRC_W]);
  assign accept = valid_q && bus.i_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    syn_d   = syn_q;
    ok_d    = ok_q;
    ovr_d   = 1'b0;
    err_d   = err_q;
    // A result leaving on this edge frees the slot for a new one
    if (done) begin
      if (!valid_q || bus.i_ready) begin
        valid_d = 1'b1;
        data_d  = cw[CW_W-1:CRC_W];
        syn_d   = syn;
        ok_d    = (syn == '0);
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
    if (accept && !ok_q && (err_q != '1)) begin
      err_d = err_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      syn_q   <= '0;
      ok_q    <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      syn_q   <= syn_d;
      ok_q    <= ok_d;
      ovr_q   <= ovr_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_data      = data_q;
  assign bus.o_syndrome  = syn_q;
  assign bus.o_crc_ok    = ok_q;
  assign bus.o_frame_err = frame_err;
  assign bus.o_overrun   = ovr_q;
  assign bus.o_err_cnt   = err_q;

endmodule
